// File: rtl/gray_decoder_seq.sv
// Multi-cycle Gray-to-binary decoder: resolves BITS_PER_CYCLE bits per clock, MSB first,
// valid/ready on both sides. Optional step checker enabled by defining GRAY_DEC_STEP_CHECK_EN.
module gray_decoder_seq #(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] gray_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] bin_out
`ifdef GRAY_DEC_STEP_CHECK_EN
   ,
   output logic             step_err
`endif
);

   localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
   localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                    state, state_next;
   logic [WIDTH-1:0]          g_sr, g_sr_next;
   logic [WIDTH-1:0]          b_sr, b_sr_next;
   logic [WIDTH-1:0]          bin_next;
   logic                      r, r_next;
   logic [CNT_W-1:0]          cnt, cnt_next;
   logic                      last_step;
   logic [BITS_PER_CYCLE-1:0] chunk;

`ifdef GRAY_DEC_STEP_CHECK_EN
   logic [WIDTH-1:0] gray_word, gray_word_next;
   logic [WIDTH-1:0] hist, hist_next;
   logic             hist_vld, hist_vld_next;
   logic             step_err_next;
`endif

   assign last_step = (cnt == CNT_W'(STEPS - 1));

   // Chained XOR over the top BITS_PER_CYCLE Gray bits, seeded by the running bit.
   always_comb begin : decode_chunk
      logic run;
      run   = r;
      chunk = '0;
      for (int j = int'(BITS_PER_CYCLE) - 1; j >= 0; j--) begin
         run      = run ^ g_sr[int'(WIDTH - BITS_PER_CYCLE) + j];
         chunk[j] = run;
      end
   end

   always_comb begin : next_state_logic
      state_next = state;
      g_sr_next  = g_sr;
      b_sr_next  = b_sr;
      r_next     = r;
      cnt_next   = cnt;
      bin_next   = bin_out;
`ifdef GRAY_DEC_STEP_CHECK_EN
      gray_word_next = gray_word;
      hist_next      = hist;
      hist_vld_next  = hist_vld;
      step_err_next  = step_err;
`endif
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               g_sr_next  = gray_in;
               b_sr_next  = '0;
               r_next     = 1'b0;
               cnt_next   = '0;
               state_next = DECODE;
`ifdef GRAY_DEC_STEP_CHECK_EN
               gray_word_next = gray_in;
`endif
            end
         end
         DECODE: begin
            g_sr_next = g_sr << BITS_PER_CYCLE;
            b_sr_next = (b_sr << BITS_PER_CYCLE) | WIDTH'(chunk);
            r_next    = chunk[0];
            cnt_next  = cnt + CNT_W'(1);
            if (last_step) begin
               state_next = DONE;
               bin_next   = b_sr_next;
`ifdef GRAY_DEC_STEP_CHECK_EN
               // A legal Gray sequence changes exactly one bit between consecutive words.
               step_err_next = hist_vld && ($countones(gray_word ^ hist) != 1);
               hist_next     = gray_word;
               hist_vld_next = 1'b1;
`endif
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         g_sr      <= '0;
         b_sr      <= '0;
         r         <= 1'b0;
         cnt       <= '0;
         bin_out   <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state     <= state_next;
         g_sr      <= g_sr_next;
         b_sr      <= b_sr_next;
         r         <= r_next;
         cnt       <= cnt_next;
         bin_out   <= bin_next;
         in_ready  <= (state_next == IDLE);
         out_valid <= (state_next == DONE);
      end
   end

`ifdef GRAY_DEC_STEP_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gray_word <= '0;
         hist      <= '0;
         hist_vld  <= 1'b0;
         step_err  <= 1'b0;
      end else begin
         gray_word <= gray_word_next;
         hist      <= hist_next;
         hist_vld  <= hist_vld_next;
         step_err  <= step_err_next;
      end
   end
`endif

endmodule
